// File: rtl/fletcher_trailer.sv
// ---------------------------------------------------------------------------
// fletcher_trailer
//
// Passes a packet of WidthHalf-bit payload words straight through to the
// output, feeds every accepted word to an external Fletcher checksum stage,
// and then appends the Width-bit checksum result as two trailer words
// (high half first, low half carries out_last).
//
// The checksum stage is outside this block. It is cleared through ck_rst,
// accumulates ck_din whenever ck_en is high, and presents its {b, a} result
// on ck_dout CkLatency cycles after its last enable.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   upstream payload word valid
//   in_ready   payload word accepted when in_valid & in_ready
//   in_data    payload word (WidthHalf bits)
//   in_last    final payload word of the packet
//   out_valid  downstream word valid
//   out_ready  downstream accepts when out_valid & out_ready
//   out_data   payload or trailer word (WidthHalf bits)
//   out_last   final word of the packet (second trailer word only)
//   ck_rst     clear to the checksum stage
//   ck_en      checksum accumulate enable
//   ck_din     checksum stage data input (always in_data)
//   ck_dout    checksum result {b, a} (Width bits)
//   pkt_words  payload word count of the current / last packet, saturating
//   pkt_done   one-cycle pulse when the last trailer word is accepted
// ---------------------------------------------------------------------------
module fletcher_trailer #(
  parameter int Width     = 32,
  parameter int CkLatency = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [Width/2-1:0]   in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [Width/2-1:0]   out_data,
  output logic                 out_last,
  output logic                 ck_rst,
  output logic                 ck_en,
  output logic [Width/2-1:0]   ck_din,
  input  logic [Width-1:0]     ck_dout,
  output logic [15:0]          pkt_words,
  output logic                 pkt_done
);

  localparam int WidthHalf = Width / 2;

  typedef enum logic [2:0] {
    PASS     = 3'd0,
    WAIT     = 3'd1,
    TRAIL_HI = 3'd2,
    TRAIL_LO = 3'd3,
    CLEAR    = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [3:0]        count_reg, count_next;
  logic [Width-1:0]  trailer_reg, trailer_next;
  logic [15:0]       words_reg, words_next;
  // High once a packet has had its first word accepted; the next accepted
  // word then continues the count instead of restarting it at 1.
  logic              open_reg, open_next;

  logic              accept;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= PASS;
      count_reg   <= 4'd0;
      trailer_reg <= '0;
      words_reg   <= 16'd0;
      open_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      trailer_reg <= trailer_next;
      words_reg   <= words_next;
      open_reg    <= open_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    trailer_next = trailer_reg;
    words_next   = words_reg;
    open_next    = open_reg;

    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = in_data;
    out_last  = 1'b0;
    ck_en     = 1'b0;
    ck_rst    = 1'b0;
    pkt_done  = 1'b0;
    accept    = 1'b0;

    case (state_reg)
      PASS: begin
        // Zero-latency passthrough: the upstream handshake is the downstream
        // handshake, so the checksum sees exactly the words that leave.
        in_ready  = out_ready;
        out_valid = in_valid;
        out_data  = in_data;
        accept    = in_valid & out_ready;
        ck_en     = accept;
        if (accept) begin
          if (!open_reg) begin
            words_next = 16'd1;
          end else if (words_reg != 16'hFFFF) begin
            words_next = words_reg + 16'd1;
          end
          open_next = ~in_last;
          if (in_last) begin
            state_next = WAIT;
            count_next = 4'(CkLatency);
          end
        end
      end

      WAIT: begin
        // Counter reaches 1 on the cycle ck_dout first holds the result of
        // the final enable; capture it there.
        count_next = count_reg - 4'd1;
        if (count_reg <= 4'd1) begin
          trailer_next = ck_dout;
          state_next   = TRAIL_HI;
        end
      end

      TRAIL_HI: begin
        out_valid = 1'b1;
        out_data  = trailer_reg[Width-1:WidthHalf];
        if (out_ready) begin
          state_next = TRAIL_LO;
        end
      end

      TRAIL_LO: begin
        out_valid = 1'b1;
        out_data  = trailer_reg[WidthHalf-1:0];
        out_last  = 1'b1;
        if (out_ready) begin
          pkt_done   = 1'b1;
          state_next = CLEAR;
        end
      end

      CLEAR: begin
        // One idle cycle to clear the checksum stage before the next packet.
        ck_rst     = 1'b1;
        state_next = PASS;
      end

      default: begin
        state_next = PASS;
      end
    endcase

    // Reset dominates every output regardless of the current state.
    if (rst) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      ck_en     = 1'b0;
      ck_rst    = 1'b1;
      pkt_done  = 1'b0;
    end
  end

  assign ck_din    = in_data;
  assign pkt_words = words_reg;

endmodule

// File: doc/fletcher_trailer.md
FLETCHER_TRAILER -- requirements
Module: fletcher_trailer

Interface
REQ-001 SHALL have parameter Width, default 32, meaning checksum width; WidthHalf = Width/2 is the derived data word width (not overridable).
REQ-002 SHALL have parameter CkLatency, default 3, meaning cycles from the last checksum enable to a valid ck_dout, range 1..15.
REQ-003 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream payload word valid.
REQ-006 SHALL have port in_ready  output  1  payload word accepted when in_valid & in_ready.
REQ-007 SHALL have port in_data  input  WidthHalf  payload word.
REQ-008 SHALL have port in_last  input  1  final payload word of packet.
REQ-009 SHALL have port out_valid  output  1  downstream word valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts when out_valid & out_ready.
REQ-011 SHALL have port out_data  output  WidthHalf  payload or trailer word.
REQ-012 SHALL have port out_last  output  1  final word of packet (second trailer word only).
REQ-013 SHALL have port ck_rst  output  1  clear to the checksum stage.
REQ-014 SHALL have port ck_en  output  1  checksum accumulate enable.
REQ-015 SHALL have port ck_din  output  WidthHalf  checksum stage data input.
REQ-016 SHALL have port ck_dout  input  Width  checksum result {b, a}.
REQ-017 SHALL have port pkt_words  output  16  payload word count of current/last packet.
REQ-018 SHALL have port pkt_done  output  1  one-cycle pulse when packet's last trailer word is accepted.

Function
REQ-019 SHALL implement states PASS, WAIT, TRAIL_HI, TRAIL_LO, CLEAR.
REQ-020 In PASS: in_ready = out_ready; out_valid = in_valid; out_data = in_data; out_last = 0 (combinational passthrough, zero latency).
REQ-021 ck_din SHALL equal in_data at all times; ck_en = in_valid & in_ready (PASS only), so the checksum sees exactly the accepted payload words.
REQ-022 Accepted word with in_last = 1 in PASS: next state WAIT, latency counter loaded with CkLatency.
REQ-023 In WAIT: in_ready = 0, out_valid = 0, ck_en = 0; counter decrements each cycle; on the cycle counter reads 1, ck_dout is latched into a Width-bit trailer register and the next state is TRAIL_HI.
REQ-024 In TRAIL_HI: out_valid = 1, out_data = trailer[Width-1:WidthHalf], out_last = 0; on handshake -> TRAIL_LO; otherwise hold stable.
REQ-025 In TRAIL_LO: out_valid = 1, out_data = trailer[WidthHalf-1:0], out_last = 1; on handshake -> CLEAR with pkt_done = 1 that cycle.
REQ-026 In CLEAR: ck_rst = 1, in_ready = 0, out_valid = 0; unconditional -> PASS next cycle. ck_rst = rst outside CLEAR.
REQ-027 In TRAIL_HI/TRAIL_LO: in_ready = 0; out_data/out_last SHALL NOT change while out_valid & !out_ready.
REQ-028 pkt_words SHALL clear to 0 on the first accepted word of a packet (replaced by 1), increment per accepted word, saturate at 0xFFFF, and hold from WAIT until the next packet's first word.
REQ-029 Single-word packet (in_last on first word) SHALL be legal and produce 1 payload + 2 trailer words, pkt_words = 1.
REQ-030 in_valid while not in PASS SHALL be ignored (not accepted, not counted, not checksummed).

Reset
REQ-031 rst SHALL, at any state including mid-trailer, force PASS, counter 0, trailer 0, pkt_words 0; during rst in_ready = 0, out_valid = 0, ck_en = 0, ck_rst = 1, pkt_done = 0.
REQ-032 A packet interrupted by rst SHALL be discarded; no trailer emitted for it.

Verification
REQ-033 Words 0x0001, 0x0002(last), out_ready=1, ck_dout model = 0x00040003 -> out: 0001, 0002, 0004, 0003(last) with 3-cycle bubble; pkt_words = 2; pkt_done one pulse.
REQ-034 Single word 0xFFFF(last), model ck_dout = 0x00000000 -> out: FFFF, 0000, 0000(last); ck_rst high exactly one cycle after.
REQ-035 out_ready toggling 1/0 every cycle over 8-word packet -> no word lost/duplicated, ck_en count = 8, trailer stable while stalled.
REQ-036 rst asserted in TRAIL_HI -> next cycle out_valid = 0, PASS; next packet 0x0005(last) yields trailer from fresh checksum, pkt_words = 1.
REQ-037 in_valid held high during WAIT/CLEAR of packet 1 -> in_ready = 0 throughout; held word accepted as first word of packet 2.
REQ-038 70000-word packet -> pkt_words saturates at 0xFFFF; trailer still emitted.
